// File: rtl/iot_event_serializer_if.sv
// Bundle between the device status source and the event serializer.
// master drives device levels and observes the event stream; slave is the serializer.
interface iot_event_serializer_if #(
   parameter int N_DEV = 8,
   parameter int IDX_W = 3
);
   logic [N_DEV-1:0] dev_status;
   logic             on_off;
   logic             change;
   logic             busy;
   logic [IDX_W-1:0] last_idx;

   modport master (
      output dev_status,
      input  on_off, change, busy, last_idx
   );

   modport slave (
      input  dev_status,
      output on_off, change, busy, last_idx
   );
endinterface

// File: rtl/iot_event_serializer.sv
// Turns per-device on/off level changes into a serial stream of one-cycle
// up/down events, lowest device index first, for the active-device monitor.
module iot_event_serializer #(
   parameter int N_DEV = 8,
   parameter int IDX_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   iot_event_serializer_if.slave   bus
);

   logic [N_DEV-1:0] s_q;
   logic [N_DEV-1:0] pend_up_q, pend_up_d;
   logic [N_DEV-1:0] pend_dn_q, pend_dn_d;
   logic             on_off_q;
   logic             change_q;
   logic             busy_q;
   logic [IDX_W-1:0] last_idx_q;

   logic [N_DEV-1:0] rise, fall, pend, emit;
   logic [IDX_W-1:0] sel;
   logic             any_pend;
   logic             sel_up;

   always_comb begin
      rise     = bus.dev_status & ~s_q;
      fall     = ~bus.dev_status & s_q;
      pend     = pend_up_q | pend_dn_q;
      sel      = '0;
      any_pend = 1'b0;
      sel_up   = 1'b0;
      // Descending scan so the lowest pending index wins.
      for (int i = N_DEV - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel      = IDX_W'(i);
            any_pend = 1'b1;
            sel_up   = pend_up_q[i];
         end
      end
      emit = '0;
      for (int i = 0; i < N_DEV; i++) begin
         emit[i] = any_pend && (sel == IDX_W'(i));
      end
   end

   always_comb begin
      pend_up_d = pend_up_q;
      pend_dn_d = pend_dn_q;
      for (int i = 0; i < N_DEV; i++) begin
         if (emit[i]) begin
            pend_up_d[i] = 1'b0;
            pend_dn_d[i] = 1'b0;
         end
         // An edge opposite to a still-queued event annihilates it; once the
         // event is already going out this cycle, the new edge is queued instead.
         if (rise[i]) begin
            if (pend_dn_q[i] && !emit[i]) pend_dn_d[i] = 1'b0;
            else                          pend_up_d[i] = 1'b1;
         end
         if (fall[i]) begin
            if (pend_up_q[i] && !emit[i]) pend_up_d[i] = 1'b0;
            else                          pend_dn_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q        <= '0;
         pend_up_q  <= '0;
         pend_dn_q  <= '0;
         on_off_q   <= 1'b0;
         change_q   <= 1'b0;
         busy_q     <= 1'b0;
         last_idx_q <= '0;
      end else begin
         s_q       <= bus.dev_status;
         pend_up_q <= pend_up_d;
         pend_dn_q <= pend_dn_d;
         on_off_q  <= any_pend;
         change_q  <= any_pend & sel_up;
         busy_q    <= |(pend_up_d | pend_dn_d);
         if (any_pend) last_idx_q <= sel;
      end
   end

   assign bus.on_off   = on_off_q;
   assign bus.change   = change_q;
   assign bus.busy     = busy_q;
   assign bus.last_idx = last_idx_q;

endmodule

// File: doc/iot_event_serializer.md
# iot_event_serializer

Upstream feeder for the active IoT devices monitor. It samples one status level per device, detects each device switching on or off, and buffers those events per device. It then replays them one per clock as the `on_off` (enable) / `change` (direction: 1 = up, 0 = down) pair the monitor counter consumes. As a result, the monitor's count always converges to the number of devices currently on.

## Interface
- `N_DEV`, default 8: number of monitored devices (2..64).
- `IDX_W`, default 3: width of `last_idx`; must satisfy 2^IDX_W >= N_DEV.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `dev_status`  in  N_DEV  per-device level, 1 = device on. Already synchronous to `clk`.
- `on_off`  out  1  registered; 1 for exactly one cycle per emitted event (monitor enable).
- `change`  out  1  registered; direction of the emitted event, 1 = device switched on, 0 = switched off. It is 0 whenever `on_off` = 0.
- `busy`  out  1  registered; 1 while any event is pending.
- `last_idx`  out  IDX_W  registered; index of the device whose event is currently on `on_off`. Holds its value otherwise.

## Operation
- State:
  - `s_q[N_DEV]`: previous sample of `dev_status`.
  - `pend_up[N_DEV]`, `pend_dn[N_DEV]`: per-device pending flags.
  - Output registers.
- Edge detection, evaluated every cycle: `rise[i] = dev_status[i] & ~s_q[i]`, `fall[i] = ~dev_status[i] & s_q[i]`. `s_q` is then loaded with `dev_status`.
- Selection: `sel` is the lowest index `i` with `pend_up[i] | pend_dn[i]`. For `sel`, `pend_up` and `pend_dn` are never both set (invariant below), so the direction is unambiguous.
- Emit per cycle when any flag is set:
  - `on_off <= 1`, `change <= pend_up[sel]`, `last_idx <= sel`.
  - The selected flag is cleared.
  - Otherwise `on_off <= 0` and `change <= 0`.
- Flag update for device `i`, applied in the same cycle as emit:
  - `rise[i]` with `pend_dn[i]` set and `i` not emitted: clear `pend_dn[i]` (on/off cancels).
  - `fall[i]` with `pend_up[i]` set and `i` not emitted: clear `pend_up[i]`.
  - `rise[i]` otherwise: set `pend_up[i]`. `fall[i]` otherwise: set `pend_dn[i]`.
  - Emitting `i` in the same cycle as a new opposite edge on `i`: the emit proceeds and the opposite flag is set.
- Invariant: at most one flag set per device. Net emitted up minus down events equals the popcount of `dev_status`, with a lag of at most N_DEV+2 cycles once inputs are stable.
- `busy <= |(next pend_up | next pend_dn)`.
- No FIFO is used, so overflow is impossible. Starvation is bounded: a device waits at most N_DEV-1 emits behind lower indices, provided lower indices do not re-toggle.

## Timing
- Reset (async, `rst` = 0):
  - `on_off` = 0, `change` = 0, `busy` = 0, `last_idx` = 0.
  - All pend flags = 0, `s_q` = 0.
  - Devices already on at release therefore produce up events, matching the monitor's reset count of 0.
- Latency: a `dev_status[i]` change ahead of clock edge k sets the flag at edge k. With no higher-priority events pending, `on_off`/`change` are high from edge k+1 to edge k+2, and the monitor counts at edge k+2.
- Throughput: one event per cycle; back-to-back `on_off` pulses are allowed.
- Reset asserted mid-operation: outputs and pending flags clear immediately, with no partial pulse. After release, events are re-derived from `dev_status` against `s_q` = 0.
- `change` and `on_off` change only on `clk` edges, and are stable for the full cycle.

## Test plan
- **Idle after reset:** reset with `dev_status` = 8'h00, release, hold 10 cycles -> `on_off` = 0, `change` = 0, `busy` = 0 throughout.
- **Single rise:** `dev_status` 8'h00 -> 8'h08 before edge k -> `on_off` = 1, `change` = 1, `last_idx` = 3 for exactly the cycle after edge k+1; then `busy` = 0 and monitor count = 1.
- **Burst, both directions:**
  - `dev_status` 8'h00 -> 8'h0F in one cycle -> four consecutive up pulses with `last_idx` 0,1,2,3; `busy` high 4 cycles.
  - Then 8'h0F -> 8'h00 -> four down pulses (`change` = 0) in order 0..3; monitor ends at 0.
- **Cancellation:** 8'h00 -> 8'h1F, then `dev_status[5]` high for one cycle while indices 0-4 are pending -> exactly 5 up pulses, none for index 5; monitor = 5.
- **Emit/opposite-edge collision:** `dev_status[0]` rises, then falls on the exact edge its up event is emitted -> up pulse followed by a down pulse for index 0; monitor returns to 0.
- **Reset mid-burst:** 8'h00 -> 8'hFF, assert `rst` after 3 pulses, release with 8'h07 held -> outputs 0 during reset, then exactly 3 up pulses (indices 0,1,2), then idle.
